// File: rtl/deser_pkg.sv
// Shared types and constants for the deserializador serial receiver.
package deser_pkg;

    localparam int         DESER_W                  = 8;
    localparam logic [7:0] DESER_SYNC_DEFAULT       = 8'hBC;
    localparam int         DESER_SYNC_COUNT_DEFAULT = 2;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } deser_state_t;

endpackage

// File: rtl/deserializador_if.sv
// Serial link receive-side bundle: serial input and resync request in,
// recovered byte, strobe and lock status out.
interface deserializador_if;

    logic                          in;
    logic                          resync;
    logic [deser_pkg::DESER_W-1:0] data;
    logic                          enb;
    logic                          lock;

    modport master (output in, output resync, input data, input enb, input lock);
    modport slave  (input in, input resync, output data, output enb, output lock);

endinterface

// File: rtl/deser_shift8.sv
// 8-bit MSB-first shift register; o_nxt is the window including the bit
// being sampled this cycle.
module deser_shift8
    import deser_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_bit,
    output logic [DESER_W-1:0] o_nxt
);

    logic [DESER_W-1:0] r_sr;

    assign o_nxt = {r_sr[DESER_W-2:0], i_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= o_nxt;
        end
    end

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receiver with sync-word alignment and lock detection.
// Optional build macro: DESER_SYNC_FILTER_EN (suppress sync words while locked).
module deserializador
    import deser_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = DESER_SYNC_DEFAULT,
    parameter int         SYNC_COUNT = DESER_SYNC_COUNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    deserializador_if.slave  bus
);

    localparam logic [3:0] LP_COUNT = 4'(SYNC_COUNT);

    deser_state_t       r_state;
    deser_state_t       w_state_nxt;
    logic [2:0]         r_cnt;
    logic [3:0]         r_matches;
    logic [DESER_W-1:0] r_data;
    logic               r_enb;
    logic [DESER_W-1:0] w_nxt;
    logic               w_is_sync;
    logic               w_boundary;
    logic               w_emit;
    logic               w_lock;

    deser_shift8 u_shift (
        .clk   (clk),
        .rst   (rst),
        .i_bit (bus.in),
        .o_nxt (w_nxt)
    );

    assign w_is_sync  = (w_nxt == SYNC_WORD);
    assign w_boundary = (r_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.resync) begin
            w_state_nxt = HUNT;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_is_sync) begin
                        w_state_nxt = (LP_COUNT == 4'd1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (w_boundary) begin
                        if (!w_is_sync) begin
                            w_state_nxt = HUNT;
                        end else if ((r_matches + 4'd1) == LP_COUNT) begin
                            w_state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED:  w_state_nxt = LOCKED;
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        w_lock = (r_state == LOCKED);
        w_emit = (r_state == LOCKED) && w_boundary && !bus.resync;
`ifdef DESER_SYNC_FILTER_EN
        // Sync words are idle fill once locked: nothing is presented for them.
        w_emit = w_emit && !w_is_sync;
`endif
    end

    // In HUNT a sync match re-anchors the bit counter to the word boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_matches <= '0;
        end else if (r_state == HUNT) begin
            if (w_is_sync && !bus.resync) begin
                r_cnt     <= '0;
                r_matches <= 4'd1;
            end
        end else begin
            r_cnt <= r_cnt + 3'd1;
            if ((r_state == CHECK) && w_boundary && w_is_sync) begin
                r_matches <= r_matches + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_enb  <= 1'b0;
        end else begin
            r_enb <= w_emit;
            if (w_emit) begin
                r_data <= w_nxt;
            end
        end
    end

    assign bus.data = r_data;
    assign bus.enb  = r_enb;
    assign bus.lock = w_lock;

endmodule

// File: doc/deserializador.md
# deserializador

Serial-to-parallel receiver for the project's 8-bit serial link. It samples one bit per `clk`, MSB first, and hunts for a configurable sync word to find word boundaries. After a programmable number of consecutive aligned sync words it declares lock, then presents each received byte on `data` with a one-cycle `enb` strobe. It sits at the far end of the link from `serializador` and restores the byte stream that block shifts out.

## Interface
- `SYNC_WORD`, 8'hBC, alignment pattern. 8'h00 and 8'hFF are illegal.
- `SYNC_COUNT`, 2, consecutive aligned sync words required for lock. Legal range 1..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `in`  in  1  serial bit, MSB first, one bit per `clk`.
- `resync`  in  1  synchronous request to drop lock and re-hunt.
- `data`  out  8  last received word, registered.
- `enb`  out  1  word-valid strobe: 1 = `data` updated this cycle (valid word), 0 = invalid/no new word.
- `lock`  out  1  1 while state = LOCKED.

## Operation
- Shift register `sr[7:0]`: every cycle `sr <= {sr[6:0], in}`. `nxt = {sr[6:0], in}` is the window that includes the bit being sampled.
- Bit counter `cnt[2:0]` wraps 7→0. A word boundary occurs on a cycle where `cnt == 7`.
- State HUNT: `cnt` is don't-care. If `nxt == SYNC_WORD`, set `cnt <= 0` and `matches <= 1`. If SYNC_COUNT = 1, go to LOCKED; otherwise go to CHECK.
- State CHECK: `cnt` increments. At a boundary:
  - If `nxt == SYNC_WORD`, `matches++`. When `matches` reaches SYNC_COUNT, go to LOCKED.
  - If `nxt != SYNC_WORD`, go to HUNT. Hunting compares again from the next cycle.
  - No words are emitted in CHECK.
- State LOCKED: `cnt` increments. At each boundary, `data <= nxt` and `enb <= 1`. `enb` is 0 on every other cycle.
- `resync = 1` in any state: next state HUNT, `lock` drops next cycle, no `enb` that cycle even at a boundary. `resync` takes priority over every other event.
- Reset mid-word: `sr`, `cnt`, and `matches` clear at once, state returns to HUNT, and the partial word is discarded.
- Reset values: `data = 8'h00`, `enb = 0`, `lock = 0`, `sr = 0`, `cnt = 0`, `matches = 0`, state HUNT.

## Timing
- Latency: the 8th bit of a word is sampled at edge N. `data` and `enb` are valid after edge N and `enb` is high for exactly one cycle.
- In LOCKED, `enb` pulses once every 8 cycles and never on consecutive cycles.
- Lock latency: the last bit of the SYNC_COUNT-th sync word is sampled at edge N. `lock` goes high after edge N. The first data word strobes 8 cycles later.
- A sync match in HUNT is detected the same edge the last sync bit is sampled; there is no extra pipeline stage.

## Configuration
- `DESER_SYNC_FILTER_EN` defined: in LOCKED, a boundary word equal to SYNC_WORD updates no output. `enb` stays 0 and `data` holds its previous value. Sync words act as idle fill.
- `DESER_SYNC_FILTER_EN` not defined: every boundary word, including SYNC_WORD, is emitted with `enb`.

## Structure
- Shared package `deser_pkg`:
  - state typedef `deser_state_t` {HUNT, CHECK, LOCKED}, 2-bit encoding.
  - default constants `DESER_SYNC_DEFAULT = 8'hBC` and `DESER_SYNC_COUNT_DEFAULT = 2`.
  - width constant `DESER_W = 8`.
- One natural sub-module, `deser_shift8`: the 8-bit shift register plus `nxt` output, with asynchronous active-low clear. FSM, counter, and output registers stay in the top module.

## Test plan
- Reset: drive `rst = 0` mid-stream → `data = 00`, `enb = 0`, `lock = 0` immediately. After release with `in = 0` held for 20 cycles → no `lock`.
- Lock with defaults: send BC, BC, then A5, 3C MSB first.
  - `lock = 1` after the 16th bit.
  - `enb` pulses after bit 24 with `data = A5`, and after bit 32 with `data = 3C`.
- Misaligned entry: 3 garbage bits 101, then BC BC 5A → lock is achieved with correct alignment and `data = 5A`.
- Failed check: BC, 77, BC, BC, 11 → CHECK falls back to HUNT on 77, locks on the later pair, and outputs `data = 11`.
- Filter: locked, send 12 BC 34.
  - With `DESER_SYNC_FILTER_EN`, `enb` pulses twice (12, 34) and `data` holds 12 during BC.
  - Without the macro, `enb` pulses three times.
- Resync: while locked, assert `resync` on a boundary cycle → no `enb` that cycle, `lock = 0` next cycle. Relock requires SYNC_COUNT new sync words.
